// File: rtl/simplez_word_tx.sv
// simplez_word_tx: output-side word transmitter for the Simplez core.
// Queues 12-bit words in a small FIFO. Each word goes off-chip as two bytes
// (low byte first, then a high byte carrying a frame marker) over a 4-phase
// strobe/ack handshake. tx_ack is asynchronous and is synchronised locally.
// Optional build macro SIMPLEZ_TX_PARITY_EN puts even parity over the word
// into bit 6 of the high byte.
module simplez_word_tx #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [11:0]                word_in,
  input  logic                       word_valid,
  output logic                       word_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_strobe,
  input  logic                       tx_ack,
  output logic                       tx_busy,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, LO_REQ, LO_REL, HI_REQ, HI_REL} state_t;

  state_t                 state;
  logic [11:0]            mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            level;
  logic [11:0]            hold;
  logic [SYNC_STAGES-1:0] ack_pipe;
  logic                   ack_s;
  logic                   push, pop;

  // High byte: marker in bit 7, upper nibble of the word in bits 3:0.
  function automatic logic [7:0] hi_byte(input logic [11:0] w);
    logic [7:0] b;
    b = {1'b1, 3'b000, w[11:8]};
`ifdef SIMPLEZ_TX_PARITY_EN
    b[6] = ^w;
`else
    b[6] = 1'b0;
`endif
    return b;
  endfunction

  assign word_ready = ena & (level != FULL);
  assign push       = word_valid & word_ready;
  // Pop only from IDLE, so one idle cycle separates back-to-back words.
  assign pop        = (state == IDLE) & ena & (level != '0);
  assign ack_s      = ack_pipe[SYNC_STAGES-1];
  assign tx_busy    = (state != IDLE) | (level != '0);
  assign fifo_level = level;

  // Storage array; pointers alone define emptiness so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_in;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Synchroniser chain for the asynchronous receiver acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_pipe <= '0;
    else        ack_pipe <= {ack_pipe[SYNC_STAGES-2:0], tx_ack};
  end

  // Handshake FSM; tx_data only changes while tx_strobe is low or being raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_data   <= 8'h00;
      tx_strobe <= 1'b0;
      hold      <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          hold      <= mem[rd_ptr];
          tx_data   <= mem[rd_ptr][7:0];
          tx_strobe <= 1'b1;
          state     <= LO_REQ;
        end
        LO_REQ: if (ack_s) begin
          tx_strobe <= 1'b0;
          state     <= LO_REL;
        end
        LO_REL: if (!ack_s) begin
          tx_data   <= hi_byte(hold);
          tx_strobe <= 1'b1;
          state     <= HI_REQ;
        end
        HI_REQ: if (ack_s) begin
          tx_strobe <= 1'b0;
          state     <= HI_REL;
        end
        HI_REL: if (!ack_s) begin
          tx_data <= 8'h00;
          state   <= IDLE;
        end
        default: begin
          tx_strobe <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simplez_word_tx.sv
// Directed bench for simplez_word_tx with a background byte receiver.
module tb_simplez_word_tx;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        ena = 0;
  logic [11:0] word_in = '0;
  logic        word_valid = 0;
  logic        word_ready;
  logic [7:0]  tx_data;
  logic        tx_strobe;
  logic        tx_ack;
  logic        tx_busy;
  logic [2:0]  fifo_level;

  logic        rx_en = 0, rx_ack = 0, man_ack = 0;
  int          ack_dly = 3;
  int          rx_cnt = 0;
  int          stab_err = 0;
  logic [7:0]  rx_cur = '0;
  logic [7:0]  rx_q[$];
  int          total = 0, bad = 0;

  assign tx_ack = rx_en ? rx_ack : man_ack;

  simplez_word_tx #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .word_in(word_in),
    .word_valid(word_valid), .word_ready(word_ready), .tx_data(tx_data),
    .tx_strobe(tx_strobe), .tx_ack(tx_ack), .tx_busy(tx_busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_hi(input logic [11:0] w);
    logic [7:0] b;
    b = {4'b1000, w[11:8]};
`ifdef SIMPLEZ_TX_PARITY_EN
    b[6] = ^w;
`endif
    return b;
  endfunction

  // Receiver: capture byte, ack after ack_dly cycles, drop ack when strobe falls.
  initial begin
    forever begin
      @(negedge clk);
      if (!rx_en) begin
        rx_ack = 0;
        rx_cnt = 0;
      end else if (rx_ack) begin
        if (!tx_strobe) rx_ack = 0;
        else if (tx_data !== rx_cur) stab_err++;
      end else if (rx_cnt > 0) begin
        if (!tx_strobe || tx_data !== rx_cur) stab_err++;
        rx_cnt--;
        if (rx_cnt == 0) rx_ack = 1;
      end else if (tx_strobe) begin
        rx_cur = tx_data;
        rx_q.push_back(tx_data);
        rx_cnt = ack_dly;
        if (rx_cnt == 0) rx_ack = 1;
      end
    end
  end

  task automatic push_word(input logic [11:0] w);
    int n = 0;
    word_in = w;
    word_valid = 1;
    while (!word_ready && n < 300) begin @(negedge clk); n++; end
    if (!word_ready) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    word_valid = 0;
  endtask

  task automatic wait_stb(input logic v, input string tag);
    int n = 0;
    while (tx_strobe !== v && n < 100) begin @(negedge clk); n++; end
    if (tx_strobe !== v) chk(tag, tx_strobe, v);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (tx_busy && n < 500) begin @(negedge clk); n++; end
    chk(tag, tx_busy, 0);
  endtask

  task automatic wait_bytes(input int cnt, input string tag);
    int n = 0;
    while (rx_q.size() < cnt && n < 1000) begin @(negedge clk); n++; end
    chk(tag, rx_q.size(), cnt);
  endtask

  task automatic exp_word(input logic [11:0] w, input string tag);
    if (rx_q.size() < 2) begin
      chk({tag, "_missing"}, rx_q.size(), 2);
    end else begin
      chk({tag, "_lo"}, rx_q.pop_front(), w[7:0]);
      chk({tag, "_hi"}, rx_q.pop_front(), exp_hi(w));
    end
  endtask

  task automatic hold_ack(input logic v, input int cyc);
    man_ack = v;
    repeat (cyc) @(negedge clk);
  endtask

  initial begin
    // ---- 1: reset values, single word 0xA5C
    repeat (3) @(negedge clk);
    chk("rst_ready", word_ready, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_strobe", tx_strobe, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_level", fifo_level, 0);
    rst_n = 1;
    ena = 1;
    @(negedge clk);
    chk("t1_ready", word_ready, 1);
    rx_en = 1;
    push_word(12'hA5C);
    chk("t1_lvl_push", fifo_level, 1);
    chk("t1_stb_early", tx_strobe, 0);
    chk("t1_busy", tx_busy, 1);
    @(posedge clk); #1;
    chk("t1_stb_first", tx_strobe, 1);
    chk("t1_data_first", tx_data, 8'h5C);
    chk("t1_lvl_pop", fifo_level, 0);
    wait_bytes(2, "t1_nbytes");
    exp_word(12'hA5C, "t1_w");
    wait_idle("t1_idle");
    chk("t1_data_idle", tx_data, 8'h00);
`ifdef SIMPLEZ_TX_PARITY_EN
    push_word(12'h001);
    wait_bytes(2, "t1p_nbytes");
    exp_word(12'h001, "t1p_w");
    wait_idle("t1p_idle");
`endif

    // ---- 2: fill with ack held low, then drain in order
    rx_en = 0;
    man_ack = 0;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) push_word(12'(i));
    chk("t2_level_full", fifo_level, 4);
    chk("t2_ready_full", word_ready, 0);
    word_in = 12'h006;
    word_valid = 1;
    repeat (5) @(negedge clk);
    chk("t2_level_hold", fifo_level, 4);
    chk("t2_ready_hold", word_ready, 0);
    chk("t2_stb_wait", tx_strobe, 1);
    rx_en = 1;
    push_word(12'h006);
    wait_bytes(12, "t2_nbytes");
    for (int i = 1; i <= 6; i++) exp_word(12'(i), "t2_w");
    wait_idle("t2_idle");

    // ---- 3: simultaneous push/pop at level 2, pointer wrap
    rx_en = 0;
    man_ack = 0;
    @(negedge clk);
    push_word(12'h100);
    push_word(12'h101);
    push_word(12'h102);
    @(negedge clk);
    chk("t3_level2", fifo_level, 2);
    wait_stb(1, "t3_stb_lo");
    chk("t3_lo", tx_data, 8'h00);
    man_ack = 1;
    wait_stb(0, "t3_rel_lo");
    man_ack = 0;
    wait_stb(1, "t3_stb_hi");
    chk("t3_hi", tx_data, exp_hi(12'h100));
    man_ack = 1;
    wait_stb(0, "t3_rel_hi");
    man_ack = 0;
    begin
      int n = 0;
      while (tx_data !== 8'h00 && n < 100) begin @(negedge clk); n++; end
    end
    chk("t3_pre_level", fifo_level, 2);
    chk("t3_pre_stb", tx_strobe, 0);
    word_in = 12'h103;
    word_valid = 1;
    @(posedge clk); #1;
    word_valid = 0;
    chk("t3_same_edge_lvl", fifo_level, 2);
    chk("t3_pop_stb", tx_strobe, 1);
    chk("t3_pop_data", tx_data, 8'h01);
    push_word(12'h104);
    push_word(12'h105);
    chk("t3_level4", fifo_level, 4);
    rx_en = 1;
    wait_bytes(10, "t3_nbytes");
    for (int i = 1; i <= 5; i++) exp_word(12'h100 + 12'(i), "t3_w");
    wait_idle("t3_idle");

    // ---- 4: ena dropped during HI_REQ
    rx_en = 0;
    man_ack = 0;
    @(negedge clk);
    push_word(12'hFFF);
    push_word(12'h123);
    wait_stb(1, "t4_stb_lo");
    chk("t4_lo", tx_data, 8'hFF);
    man_ack = 1;
    wait_stb(0, "t4_rel_lo");
    man_ack = 0;
    wait_stb(1, "t4_stb_hi");
    chk("t4_hi", tx_data, 8'h8F);
    ena = 0;
    @(negedge clk);
    chk("t4_ready_off", word_ready, 0);
    man_ack = 1;
    wait_stb(0, "t4_rel_hi");
    hold_ack(0, 10);
    chk("t4_no_pop_stb", tx_strobe, 0);
    chk("t4_no_pop_data", tx_data, 8'h00);
    chk("t4_kept_level", fifo_level, 1);
    chk("t4_busy", tx_busy, 1);
    ena = 1;
    rx_en = 1;
    wait_bytes(2, "t4_nbytes");
    exp_word(12'h123, "t4_w");
    wait_idle("t4_idle");

    // ---- 5: async reset during LO_REQ
    rx_en = 0;
    man_ack = 0;
    @(negedge clk);
    push_word(12'h555);
    push_word(12'h666);
    wait_stb(1, "t5_stb");
    chk("t5_level_pre", fifo_level, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t5_rst_stb", tx_strobe, 0);
    chk("t5_rst_level", fifo_level, 0);
    chk("t5_rst_busy", tx_busy, 0);
    @(negedge clk);
    rst_n = 1;
    rx_en = 1;
    @(negedge clk);
    push_word(12'h7E1);
    wait_bytes(2, "t5_nbytes");
    exp_word(12'h7E1, "t5_w");
    wait_idle("t5_idle");
    chk("t5_extra", rx_q.size(), 0);

    // ---- 6: ack held >= SYNC_STAGES+1 cycles advances exactly one state
    rx_en = 0;
    man_ack = 0;
    @(negedge clk);
    push_word(12'h3C6);
    wait_stb(1, "t6_stb");
    hold_ack(1, 6);
    chk("t6_lorel_stb", tx_strobe, 0);
    chk("t6_lorel_data", tx_data, 8'hC6);
    hold_ack(0, 6);
    chk("t6_hireq_stb", tx_strobe, 1);
    chk("t6_hireq_data", tx_data, exp_hi(12'h3C6));
    hold_ack(1, 6);
    chk("t6_hirel_stb", tx_strobe, 0);
    chk("t6_hirel_data", tx_data, exp_hi(12'h3C6));
    hold_ack(0, 6);
    chk("t6_idle_data", tx_data, 8'h00);
    chk("t6_idle_busy", tx_busy, 0);

    chk("stable_data", stab_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
